// File: rtl/sdp_ram_ctrl.sv
// sdp_ram_ctrl: simple-dual-port synchronous RAM (1 write, 1 read port) with
// byte-enable writes, 1- or 2-cycle pipelined reads with a valid strobe,
// selectable read-during-write result and a zero-fill clear engine that runs
// after reset and on request.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   clr           in   start a zero-fill sweep (honoured only in RUN)
//   wr_en         in   write request
//   wr_addr       in   write address
//   wr_data       in   write data
//   wr_be         in   byte enables, bit i -> wr_data[8i+7:8i]
//   rd_en         in   read request
//   rd_addr       in   read address
//   rd_data       out  read data, valid with rd_valid, holds otherwise
//   rd_valid      out  one-cycle strobe per accepted read
//   rd_collision  out  that read met a same-cycle write to the same address
//   busy          out  clear sweep active; requests ignored
module sdp_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_collision,
  output logic                    busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  // Parameter legality checks at elaboration
  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
    $error("sdp_ram_ctrl: RD_LAT must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("sdp_ram_ctrl: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;
  logic                    w_clr_we;
  logic                    r_busy;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_coll;
  logic [DATA_WIDTH-1:0]   w_rd_old;
  logic [DATA_WIDTH-1:0]   w_rd_merge;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  logic                    r_vld;
  logic                    r_coll;
  logic [DATA_WIDTH-1:0]   r_data;

  // Requests are only honoured outside the clear sweep
  assign w_wr_acc = (r_state == ST_RUN) && wr_en;
  assign w_rd_acc = (r_state == ST_RUN) && rd_en;
  assign w_coll   = w_rd_acc && w_wr_acc && (rd_addr == wr_addr);

  // FSM state and sweep counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_busy    <= (w_state_nxt == ST_INIT);
    end
  end

  // FSM next state: INIT sweeps every address once, RUN waits for clr
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clr_we = 1'b1;
        if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          w_state_nxt   = ST_RUN;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (clr) begin
          w_state_nxt   = ST_INIT;
          w_clr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_INIT;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  // Storage array: clear-engine writes and byte-enabled user writes are exclusive
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wr_be[b]) begin
          r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read word: old array contents, or the byte-merged write word on a collision
  always_comb begin
    w_rd_old   = r_mem[rd_addr];
    w_rd_merge = w_rd_old;
    for (int b = 0; b < int'(NB); b++) begin
      if (wr_be[b]) begin
        w_rd_merge[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    w_rd_word = ((RDW_MODE != 0) && w_coll) ? w_rd_merge : w_rd_old;
  end

  // Read pipeline; data registers only load on a valid read so rd_data holds
  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_coll <= 1'b0;
        r_data <= '0;
      end else begin
        r_vld  <= w_rd_acc;
        r_coll <= w_coll;
        if (w_rd_acc) begin
          r_data <= w_rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic                  r_s1_vld;
    logic                  r_s1_coll;
    logic [DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_vld  <= 1'b0;
        r_s1_coll <= 1'b0;
        r_s1_data <= '0;
        r_vld     <= 1'b0;
        r_coll    <= 1'b0;
        r_data    <= '0;
      end else begin
        r_s1_vld  <= w_rd_acc;
        r_s1_coll <= w_coll;
        if (w_rd_acc) begin
          r_s1_data <= w_rd_word;
        end
        r_vld  <= r_s1_vld;
        r_coll <= r_s1_vld && r_s1_coll;
        if (r_s1_vld) begin
          r_data <= r_s1_data;
        end
      end
    end
  end

  assign rd_data      = r_data;
  assign rd_valid     = r_vld;
  assign rd_collision = r_coll;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// Scoreboard bench for sdp_ram_ctrl. Two instances share one stimulus stream:
// dut 0 = RD_LAT 1 / old-word on collision, dut 1 = RD_LAT 2 / merged word.
module tb_sdp_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;
  logic        a_rd_coll, b_rd_coll;
  logic        a_busy, b_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        coll;
  } exp_t;

  exp_t sbq[2][$];

  sdp_ram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LAT(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_collision(a_rd_coll), .busy(a_busy)
  );

  sdp_ram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LAT(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_collision(b_rd_coll), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pop and compare whenever either instance presents rd_valid
  logic        m_v;
  logic        m_c;
  logic [31:0] m_d;
  exp_t        m_e;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_v = (d == 0) ? a_rd_valid : b_rd_valid;
      m_c = (d == 0) ? a_rd_coll  : b_rd_coll;
      m_d = (d == 0) ? a_rd_data  : b_rd_data;
      if (m_v) begin
        if (sbq[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL dut%0d unexpected rd_valid: got data %h want no strobe (cycle %0d)", d, m_d, cyc);
        end else begin
          m_e = sbq[d].pop_front();
          chk($sformatf("dut%0d rd_data", d), m_d, m_e.data);
          chk($sformatf("dut%0d rd_collision", d), 32'(m_c), 32'(m_e.coll));
          chk($sformatf("dut%0d rd_valid cycle", d), 32'(cyc), 32'(m_e.due));
        end
      end else if (sbq[d].size() > 0 && sbq[d][0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL dut%0d missing rd_valid: got none want data %h due cycle %0d", d, sbq[d][0].data, sbq[d][0].due);
        void'(sbq[d].pop_front());
      end
    end
  end

  task automatic push_exp(input int d, input int due, input logic [31:0] data, input logic coll);
    exp_t e;
    e.due  = due;
    e.data = data;
    e.coll = coll;
    sbq[d].push_back(e);
  endtask

  // One request cycle; inputs return to idle after the sampling edge
  task automatic drive(input logic w, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] wbe,
                       input logic r, input logic [3:0] ra, input logic [31:0] ea, input logic [31:0] eb,
                       input logic ec, input logic c);
    wr_en = w; wr_addr = wa; wr_data = wd; wr_be = wbe;
    rd_en = r; rd_addr = ra; clr = c;
    if (r) begin
      push_exp(0, cyc + 1, ea, ec);
      push_exp(1, cyc + 2, eb, ec);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_be = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b1, a, d, be, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, a, e, e, 1'b0, 1'b0);
  endtask

  // Count negedges with busy high; optionally pulse clr mid-sweep
  task automatic count_busy(input string nm, input int pulse_at);
    int na = 0;
    int nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_busy) na++;
      if (b_busy) nb++;
      clr = (pulse_at != 0) && (na == pulse_at);
      if (!a_busy && !b_busy) break;
    end
    clr = 1'b0;
    chk({nm, " busy cycles dut0"}, 32'(na), 32'd16);
    chk({nm, " busy cycles dut1"}, 32'(nb), 32'd16);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " dut0 rd_valid"}, 32'(a_rd_valid), 32'd0);
    chk({nm, " dut1 rd_valid"}, 32'(b_rd_valid), 32'd0);
    chk({nm, " dut0 busy"}, 32'(a_busy), 32'd1);
    chk({nm, " dut1 busy"}, 32'(b_busy), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'h0;
    wr_be = 4'h0; rd_en = 1'b0; rd_addr = 4'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset dut0 rd_data", a_rd_data, 32'h0);
    chk("reset dut1 rd_data", b_rd_data, 32'h0);
    chk("reset dut0 rd_collision", 32'(a_rd_coll), 32'd0);
    chk("reset dut1 rd_collision", 32'(b_rd_coll), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy("init", 0);

    // Whole array zero-filled
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);

    // Byte-enable merge
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3, 32'hDE22BE44);

    // Back-to-back reads
    wr(4'd1, 32'h1, 4'hF);
    wr(4'd2, 32'h2, 4'hF);
    wr(4'd3, 32'h3, 4'hF);
    rd(4'd1, 32'h1);
    rd(4'd2, 32'h2);
    rd(4'd3, 32'h3);

    // Read-during-write, full and partial byte enables, then different address
    wr(4'd5, 32'hAAAAAAAA, 4'hF);
    drive(1'b1, 4'd5, 32'h55555555, 4'hF, 1'b1, 4'd5, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
    drive(1'b1, 4'd5, 32'h12345678, 4'h3, 1'b1, 4'd5, 32'h55555555, 32'h55555678, 1'b1, 1'b0);
    drive(1'b1, 4'd6, 32'h00000066, 4'hF, 1'b1, 4'd5, 32'h55555678, 32'h55555678, 1'b0, 1'b0);
    wr(4'd6, 32'hFFFFFFFF, 4'h0);
    rd(4'd6, 32'h00000066);
    rd(4'd5, 32'h55555678);
    wr(4'd9, 32'h00000009, 4'hF);
    rd(4'd9, 32'h00000009);

    // Read then clear: read completes, requests during sweep ignored, clr mid-sweep ignored
    wr(4'd7, 32'h00000077, 4'hF);
    rd(4'd7, 32'h00000077);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    rd_en = 1'b1; rd_addr = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h00000BAD; wr_be = 4'hF;
    count_busy("clr", 8);
    rd_en = 1'b0; wr_en = 1'b0; wr_be = 4'h0;
    rd(4'd7, 32'h0);
    rd(4'd2, 32'h0);

    // Async reset with a read in flight
    wr(4'd4, 32'h00000044, 4'hF);
    rd_en = 1'b1; rd_addr = 4'd4;
    @(posedge clk);
    #1 rd_en = 1'b0;
    chk("pre-reset dut0 rd_valid", 32'(a_rd_valid), 32'd1);
    rst_n = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    #1;
    check_reset_outputs("flight reset");
    chk("flight reset dut0 rd_data", a_rd_data, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy("flight release", 0);

    // Async reset mid-sweep with counter at 9; sweep restarts from 0
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("mid-sweep dut0 busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    #1;
    check_reset_outputs("mid-sweep reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy("mid-sweep release", 0);
    rd(4'd4, 32'h0);
    wr(4'd10, 32'hCAFEF00D, 4'hF);
    rd(4'd10, 32'hCAFEF00D);

    repeat (4) @(negedge clk);
    chk("dut0 scoreboard drained", 32'(sbq[0].size()), 32'd0);
    chk("dut1 scoreboard drained", 32'(sbq[1].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
